// File: rtl/soc_mgmt_pkg.sv
// Shared types for the soc_mgmt clock frequency-change sequencer.
// Field widths match the default parameterisation (7 SYS_CLKs, 3 PLLs, 4-bit divisor).
package soc_mgmt_pkg;

    localparam int unsigned FREQ_SEQ_CNT_W  = 16;
    localparam int unsigned FREQ_CLK_IDX_W  = 3;
    localparam int unsigned FREQ_PLL_IDX_W  = 2;
    localparam int unsigned FREQ_DIV_W      = 4;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CHECK    = 4'd1,
        ST_PARK     = 4'd2,
        ST_PLL_RST  = 4'd3,
        ST_PLL_LOCK = 4'd4,
        ST_PLL_SEL  = 4'd5,
        ST_DIV      = 4'd6,
        ST_UNPARK   = 4'd7,
        ST_ERR      = 4'd8,
        ST_DONE     = 4'd9
    } freq_seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_BAD_IDX    = 2'd1,
        ERR_PLL_SHARED = 2'd2,
        ERR_TIMEOUT    = 2'd3
    } freq_seq_err_e;

    typedef struct packed {
        logic [FREQ_CLK_IDX_W-1:0] clk_idx;
        logic [FREQ_PLL_IDX_W-1:0] pll_idx;
        logic                      reprog_pll;
        logic [9:0]                div_main;
        logic [5:0]                div_pre;
        logic [2:0]                div_scalar;
        logic [FREQ_DIV_W-1:0]     divisor;
    } freq_req_t;

endpackage

// File: rtl/axe_tcl_seq_sync.sv
// Multi-stage flop synchroniser for a single asynchronous level signal.
module axe_tcl_seq_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SyncStages-1:0] stage_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SyncStages-2:0], i_d};
        end
    end

    assign o_q = stage_q[SyncStages-1];

endmodule

// File: rtl/soc_mgmt_clk_freq_seq_timer.sv
// Loadable 16-bit down-counter; saturates at zero and flags expiry while zero.
module soc_mgmt_clk_freq_seq_timer
    import soc_mgmt_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load,
    input  logic [FREQ_SEQ_CNT_W-1:0] i_load_val,
    output logic                      o_expired
);

    logic [FREQ_SEQ_CNT_W-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_load) begin
            count_q <= i_load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign o_expired = (count_q == '0);

endmodule

// File: rtl/soc_mgmt_clk_freq_seq.sv
// Frequency-change sequencer: parks a SYS_CLK on REF_CLK, optionally re-locks its PLL,
// reselects the PLL and divisor, then unparks it. One request in flight at a time.
module soc_mgmt_clk_freq_seq
    import soc_mgmt_pkg::*;
#(
    parameter int NumPll          = 3,
    parameter int NumSysClk       = 7,
    parameter int DivW            = 4,
    parameter int ResetHoldCycles = 32,
    parameter int LockTimeout     = 16'hFFFF,
    parameter int MuxTimeout      = 1024,
    parameter int SettleCycles    = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [$clog2(NumSysClk)-1:0] i_req_clk_idx,
    input  logic [$clog2(NumPll)-1:0]   i_req_pll_idx,
    input  logic                        i_req_reprog_pll,
    input  logic [9:0]                  i_req_div_main,
    input  logic [5:0]                  i_req_div_pre,
    input  logic [2:0]                  i_req_div_scalar,
    input  logic [DivW-1:0]             i_req_divisor,
    output logic                        o_done,
    output logic [1:0]                  o_error,
    output logic [NumPll-1:0]           o_pll_resetb,
    output logic [NumPll*10-1:0]        o_pll_div_main,
    output logic [NumPll*6-1:0]         o_pll_div_pre,
    output logic [NumPll*3-1:0]         o_pll_div_scalar,
    input  logic [NumPll-1:0]           i_pll_lock,
    output logic [NumSysClk-1:0]        o_pll_mux_select,
    output logic [NumSysClk-1:0]        o_div_mux_select,
    input  logic [NumSysClk-1:0]        i_div_mux_on_div,
    output logic [NumSysClk*DivW-1:0]   o_divisor,
    output logic [NumSysClk-1:0]        o_divisor_updated,
    output freq_seq_state_e             o_state
);

    localparam int unsigned PllIdxW = $clog2(NumPll);

    localparam logic [FREQ_SEQ_CNT_W-1:0] HoldLoad   = FREQ_SEQ_CNT_W'(ResetHoldCycles - 1);
    localparam logic [FREQ_SEQ_CNT_W-1:0] LockLoad   = FREQ_SEQ_CNT_W'(LockTimeout);
    localparam logic [FREQ_SEQ_CNT_W-1:0] MuxLoad    = FREQ_SEQ_CNT_W'(MuxTimeout);
    localparam logic [FREQ_SEQ_CNT_W-1:0] SettleLoad = FREQ_SEQ_CNT_W'(SettleCycles - 1);

    // Valid/ready: a request transfers on the cycle both are high; ready is only
    // asserted in IDLE once reset has been released, and nothing is queued.

    freq_seq_state_e state_q, state_d;
    freq_seq_err_e   err_q, err_d;
    freq_req_t       req_q;
    logic            ready_en_q;
    logic            accept;

    logic [NumPll-1:0]             resetb_q;
    logic [NumPll-1:0][9:0]        div_main_q;
    logic [NumPll-1:0][5:0]        div_pre_q;
    logic [NumPll-1:0][2:0]        div_scalar_q;
    logic [NumSysClk-1:0]          pll_sel_q;
    logic [NumSysClk-1:0]          div_sel_q;
    logic [NumSysClk-1:0]          updated_q;
    logic [NumSysClk-1:0][DivW-1:0] divisor_q;

    logic [NumPll-1:0]    lock_sync;
    logic [NumSysClk-1:0] clk_oh;
    logic [NumPll-1:0]    pll_oh;
    logic                 clk_ok, pll_ok, shared;
    logic                 div_sel_c, on_div_c, lock_p;
    logic                 entering;
    logic [FREQ_SEQ_CNT_W-1:0] cnt_load_val;
    logic                 cnt_expired;

    for (genvar k = 0; k < NumPll; k++) begin : g_lock_sync
        axe_tcl_seq_sync #(.SyncStages(2)) u_lock_sync (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_d    (i_pll_lock[k]),
            .o_q    (lock_sync[k])
        );
    end

    soc_mgmt_clk_freq_seq_timer u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (entering),
        .i_load_val(cnt_load_val),
        .o_expired (cnt_expired)
    );

    // Decode the latched request; out-of-range indices simply decode to all-zero one-hots.
    always_comb begin
        clk_ok = int'(req_q.clk_idx) < NumSysClk;
        pll_ok = int'(req_q.pll_idx) < NumPll;
        clk_oh = '0;
        pll_oh = '0;
        shared = 1'b0;
        for (int j = 0; j < NumSysClk; j++) begin
            clk_oh[j] = (int'(req_q.clk_idx) == j);
        end
        for (int k = 0; k < NumPll; k++) begin
            pll_oh[k] = (int'(req_q.pll_idx) == k);
        end
        for (int j = 0; j < NumSysClk; j++) begin
            if (!clk_oh[j] && div_sel_q[j] && (req_q.pll_idx == PllIdxW'(pll_sel_q[j]))) begin
                shared = 1'b1;
            end
        end
        div_sel_c = |(div_sel_q & clk_oh);
        on_div_c  = |(i_div_mux_on_div & clk_oh);
        lock_p    = |(lock_sync & pll_oh);
    end

    assign accept = i_req_valid && o_req_ready;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CHECK;
                    err_d   = ERR_OK;
                end
            end
            ST_CHECK: begin
                if (!clk_ok || !pll_ok) begin
                    state_d = ST_DONE;
                    err_d   = ERR_BAD_IDX;
                end else if (req_q.reprog_pll && shared) begin
                    state_d = ST_DONE;
                    err_d   = ERR_PLL_SHARED;
                end else if (div_sel_c) begin
                    state_d = ST_PARK;
                end else begin
                    state_d = req_q.reprog_pll ? ST_PLL_RST : ST_PLL_SEL;
                end
            end
            ST_PARK: begin
                if (!on_div_c) begin
                    state_d = req_q.reprog_pll ? ST_PLL_RST : ST_PLL_SEL;
                end else if (cnt_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_PLL_RST: begin
                if (cnt_expired) state_d = ST_PLL_LOCK;
            end
            ST_PLL_LOCK: begin
                // Lock is checked first so it wins a tie with expiry.
                if (lock_p) begin
                    state_d = ST_PLL_SEL;
                end else if (cnt_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_PLL_SEL: begin
                if (cnt_expired) state_d = ST_DIV;
            end
            ST_DIV: begin
                if (cnt_expired) state_d = ST_UNPARK;
            end
            ST_UNPARK: begin
                if (on_div_c) begin
                    state_d = ST_DONE;
                end else if (cnt_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                state_d = ST_DONE;
                err_d   = ERR_TIMEOUT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign entering = (state_d != state_q);

    always_comb begin
        cnt_load_val = '0;
        case (state_d)
            ST_PARK, ST_UNPARK:   cnt_load_val = MuxLoad;
            ST_PLL_RST:           cnt_load_val = HoldLoad;
            ST_PLL_LOCK:          cnt_load_val = LockLoad;
            ST_PLL_SEL, ST_DIV:   cnt_load_val = SettleLoad;
            default:              cnt_load_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            err_q        <= ERR_OK;
            ready_en_q   <= 1'b0;
            req_q        <= '0;
            resetb_q     <= '0;
            div_main_q   <= '0;
            div_pre_q    <= '0;
            div_scalar_q <= '0;
            pll_sel_q    <= '0;
            div_sel_q    <= '0;
            updated_q    <= '0;
            divisor_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
            updated_q  <= '0;
            if (accept) begin
                req_q.clk_idx    <= i_req_clk_idx;
                req_q.pll_idx    <= i_req_pll_idx;
                req_q.reprog_pll <= i_req_reprog_pll;
                req_q.div_main   <= i_req_div_main;
                req_q.div_pre    <= i_req_div_pre;
                req_q.div_scalar <= i_req_div_scalar;
                req_q.divisor    <= i_req_divisor;
            end
            // Output actions happen once, on entry to the state that owns them.
            if (entering) begin
                case (state_d)
                    ST_PARK: div_sel_q <= div_sel_q & ~clk_oh;
                    ST_PLL_RST: begin
                        resetb_q <= resetb_q & ~pll_oh;
                        for (int k = 0; k < NumPll; k++) begin
                            if (pll_oh[k]) begin
                                div_main_q[k]   <= req_q.div_main;
                                div_pre_q[k]    <= req_q.div_pre;
                                div_scalar_q[k] <= req_q.div_scalar;
                            end
                        end
                    end
                    ST_PLL_LOCK: resetb_q <= resetb_q | pll_oh;
                    ST_PLL_SEL: begin
                        for (int j = 0; j < NumSysClk; j++) begin
                            if (clk_oh[j]) pll_sel_q[j] <= req_q.pll_idx[0];
                        end
                    end
                    ST_DIV: begin
                        updated_q <= clk_oh;
                        for (int j = 0; j < NumSysClk; j++) begin
                            if (clk_oh[j]) divisor_q[j] <= req_q.divisor;
                        end
                    end
                    ST_UNPARK: div_sel_q <= div_sel_q | clk_oh;
                    ST_ERR: begin
                        div_sel_q <= div_sel_q & ~clk_oh;
                        if (req_q.reprog_pll) resetb_q <= resetb_q & ~pll_oh;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_req_ready       = ready_en_q && (state_q == ST_IDLE);
    assign o_done            = (state_q == ST_DONE);
    assign o_error           = err_q;
    assign o_pll_resetb      = resetb_q;
    assign o_pll_div_main    = div_main_q;
    assign o_pll_div_pre     = div_pre_q;
    assign o_pll_div_scalar  = div_scalar_q;
    assign o_pll_mux_select  = pll_sel_q;
    assign o_div_mux_select  = div_sel_q;
    assign o_divisor         = divisor_q;
    assign o_divisor_updated = updated_q;
    assign o_state           = state_q;

endmodule

// File: tb/tb_soc_mgmt_clk_freq_seq.sv
// Directed bench for the clock frequency-change sequencer with a simple mux/PLL model.
module tb_soc_mgmt_clk_freq_seq;
    import soc_mgmt_pkg::*;

    localparam int NP = 3;
    localparam int NC = 7;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_clk_idx = '0;
    logic [1:0]       req_pll_idx = '0;
    logic             req_reprog = 1'b0;
    logic [9:0]       req_m = '0;
    logic [5:0]       req_p = '0;
    logic [2:0]       req_s = '0;
    logic [DW-1:0]    req_div = '0;
    logic             done;
    logic [1:0]       error;
    logic [NP-1:0]    resetb;
    logic [NP*10-1:0] div_main;
    logic [NP*6-1:0]  div_pre;
    logic [NP*3-1:0]  div_scalar;
    logic [NP-1:0]    pll_lock = '0;
    logic [NC-1:0]    pll_sel;
    logic [NC-1:0]    div_sel;
    logic [NC-1:0]    on_div;
    logic [NC*DW-1:0] divisor;
    logic [NC-1:0]    updated;
    freq_seq_state_e  state;

    // Divider mux status follows its select two ref cycles later.
    logic [NC-1:0] mux_d1 = '0;
    logic [NC-1:0] mux_d2 = '0;
    always @(posedge clk) begin
        mux_d1 <= div_sel;
        mux_d2 <= mux_d1;
    end
    assign on_div = mux_d2;

    soc_mgmt_clk_freq_seq #(.LockTimeout(100)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_clk_idx    (req_clk_idx),
        .i_req_pll_idx    (req_pll_idx),
        .i_req_reprog_pll (req_reprog),
        .i_req_div_main   (req_m),
        .i_req_div_pre    (req_p),
        .i_req_div_scalar (req_s),
        .i_req_divisor    (req_div),
        .o_done           (done),
        .o_error          (error),
        .o_pll_resetb     (resetb),
        .o_pll_div_main   (div_main),
        .o_pll_div_pre    (div_pre),
        .o_pll_div_scalar (div_scalar),
        .i_pll_lock       (pll_lock),
        .o_pll_mux_select (pll_sel),
        .o_div_mux_select (div_sel),
        .i_div_mux_on_div (on_div),
        .o_divisor        (divisor),
        .o_divisor_updated(updated),
        .o_state          (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         obs_cycles, obs_low, obs_upd, obs_park, obs_wait;
    logic       obs_done, obs_hi, obs_rb_changed;
    logic [1:0] obs_err;

    // Issue one request and watch it for up to budget samples (one per negedge).
    // Sample n is taken after the (n-1)th rising edge following the accepting edge.
    task automatic run_req(input int c, input int p, input logic rp, input logic [9:0] m,
                           input logic [5:0] pp, input logic [2:0] s, input logic [DW-1:0] dv,
                           input int lock_delay, input int budget);
        int hi_cnt;
        logic seen_low;
        logic [NP-1:0] rb0;
        hi_cnt = 0; seen_low = 1'b0; rb0 = resetb;
        obs_cycles = 0; obs_low = 0; obs_upd = 0; obs_park = 0; obs_wait = 0;
        obs_done = 1'b0; obs_hi = 1'b0; obs_rb_changed = 1'b0; obs_err = 2'd0;
        req_clk_idx = 3'(c); req_pll_idx = 2'(p); req_reprog = rp;
        req_m = m; req_p = pp; req_s = s; req_div = dv;
        req_valid = 1'b1;
        while (!req_ready && obs_wait < 20) begin
            @(negedge clk);
            obs_wait++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            for (int k = 0; k < NP; k++) if (!resetb[k]) pll_lock[k] = 1'b0;
            if (resetb !== rb0) obs_rb_changed = 1'b1;
            if (p < NP) begin
                if (!resetb[p]) begin
                    seen_low = 1'b1;
                    obs_low++;
                end else if (seen_low) begin
                    obs_hi = 1'b1;
                    hi_cnt++;
                    if (lock_delay >= 0 && hi_cnt == lock_delay) pll_lock[p] = 1'b1;
                end
            end
            if (c < NC) begin
                if (updated[c]) obs_upd++;
                if (!div_sel[c]) obs_park++;
            end
            if (done) begin
                obs_done = 1'b1;
                obs_err = error;
                obs_cycles = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %b want 1", req_ready); end
        n_checks++; if (resetb !== 3'b000) begin n_fail++; $display("FAIL reset_resetb: got %b want 000", resetb); end
        n_checks++; if ({pll_sel, div_sel} !== 14'b0) begin n_fail++; $display("FAIL reset_selects: got %b want 0", {pll_sel, div_sel}); end
        n_checks++; if ({divisor, div_main, updated} !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {divisor, div_main, updated}); end
        n_checks++; if ({done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_done_err: got %b want 000", {done, error}); end
    endtask

    task automatic test_reprog_lock();
        run_req(1, 0, 1'b1, 10'd100, 6'd3, 3'd1, 4'd2, 50, 400);
        n_checks++; if ({obs_done, obs_err} !== 3'b100) begin n_fail++; $display("FAIL reprog_done: got %b want 100", {obs_done, obs_err}); end
        // resetb[0] is already low from reset, so the CHECK cycle adds one to the 32-cycle hold.
        n_checks++; if (obs_low !== 33) begin n_fail++; $display("FAIL reprog_resetb_low: got %0d want 33", obs_low); end
        n_checks++; if (obs_upd !== 1) begin n_fail++; $display("FAIL reprog_upd_strobes: got %0d want 1", obs_upd); end
        n_checks++; if (divisor[7:4] !== 4'd2) begin n_fail++; $display("FAIL reprog_divisor: got %0d want 2", divisor[7:4]); end
        n_checks++; if ({pll_sel[1], div_sel[1]} !== 2'b01) begin n_fail++; $display("FAIL reprog_selects: got %b want 01", {pll_sel[1], div_sel[1]}); end
        n_checks++; if ({div_main[9:0], div_pre[5:0], div_scalar[2:0]} !== {10'd100, 6'd3, 3'd1}) begin
            n_fail++; $display("FAIL reprog_mps: got %0d/%0d/%0d want 100/3/1", div_main[9:0], div_pre[5:0], div_scalar[2:0]);
        end
        n_checks++; if (resetb !== 3'b001) begin n_fail++; $display("FAIL reprog_resetb_end: got %b want 001", resetb); end
    endtask

    task automatic test_parked_latency();
        run_req(2, 1, 1'b0, 10'd0, 6'd0, 3'd0, 4'd3, -1, 200);
        // CHECK 1 + two 16-cycle settles + 3-cycle unpark handshake + DONE 1.
        n_checks++; if ({obs_done, obs_err} !== 3'b100) begin n_fail++; $display("FAIL parked_done: got %b want 100", {obs_done, obs_err}); end
        n_checks++; if (obs_cycles !== 37) begin n_fail++; $display("FAIL parked_latency: got %0d want 37", obs_cycles); end
        n_checks++; if (divisor[11:8] !== 4'd3) begin n_fail++; $display("FAIL parked_divisor: got %0d want 3", divisor[11:8]); end
        n_checks++; if ({pll_sel[2], div_sel[2]} !== 2'b11) begin n_fail++; $display("FAIL parked_selects: got %b want 11", {pll_sel[2], div_sel[2]}); end
    endtask

    task automatic test_park_change();
        run_req(2, 1, 1'b0, 10'd0, 6'd0, 3'd0, 4'd5, -1, 200);
        n_checks++; if ({obs_done, obs_err} !== 3'b100) begin n_fail++; $display("FAIL park_done: got %b want 100", {obs_done, obs_err}); end
        n_checks++; if (obs_cycles !== 40) begin n_fail++; $display("FAIL park_latency: got %0d want 40", obs_cycles); end
        n_checks++; if (obs_park !== 35) begin n_fail++; $display("FAIL park_ref_cycles: got %0d want 35", obs_park); end
        n_checks++; if (obs_upd !== 1) begin n_fail++; $display("FAIL park_upd_strobes: got %0d want 1", obs_upd); end
        n_checks++; if (divisor[11:8] !== 4'd5) begin n_fail++; $display("FAIL park_divisor: got %0d want 5", divisor[11:8]); end
        n_checks++; if (obs_rb_changed !== 1'b0) begin n_fail++; $display("FAIL park_resetb_changed: got %b want 0", obs_rb_changed); end
    endtask

    task automatic test_lock_timeout();
        run_req(4, 2, 1'b1, 10'd300, 6'd7, 3'd2, 4'd9, -1, 300);
        // CHECK 1 + hold 32 + lock window 101 + ERR 1 + DONE 1.
        n_checks++; if ({obs_done, obs_err} !== 3'b111) begin n_fail++; $display("FAIL timeout_done: got %b want 111", {obs_done, obs_err}); end
        n_checks++; if (obs_cycles !== 136) begin n_fail++; $display("FAIL timeout_latency: got %0d want 136", obs_cycles); end
        n_checks++; if (obs_hi !== 1'b1) begin n_fail++; $display("FAIL timeout_resetb_released: got %b want 1", obs_hi); end
        n_checks++; if ({div_sel[4], resetb} !== 4'b0001) begin n_fail++; $display("FAIL timeout_outputs: got %b want 0001", {div_sel[4], resetb}); end
        n_checks++; if (div_main[29:20] !== 10'd300) begin n_fail++; $display("FAIL timeout_m: got %0d want 300", div_main[29:20]); end
    endtask

    task automatic test_back_to_back();
        run_req(1, 0, 1'b1, 10'd200, 6'd4, 3'd3, 4'd6, 10, 400);
        n_checks++; if ({obs_done, obs_err} !== 3'b100) begin n_fail++; $display("FAIL b2b_first_done: got %b want 100", {obs_done, obs_err}); end
        n_checks++; if (obs_low !== 32) begin n_fail++; $display("FAIL b2b_resetb_low: got %0d want 32", obs_low); end
        n_checks++; if (div_main[9:0] !== 10'd200) begin n_fail++; $display("FAIL b2b_m: got %0d want 200", div_main[9:0]); end
        run_req(0, 0, 1'b0, 10'd0, 6'd0, 3'd0, 4'd1, -1, 200);
        n_checks++; if (obs_wait !== 1) begin n_fail++; $display("FAIL b2b_ready_wait: got %0d want 1", obs_wait); end
        n_checks++; if ({obs_done, obs_err} !== 3'b100) begin n_fail++; $display("FAIL b2b_second_done: got %b want 100", {obs_done, obs_err}); end
        n_checks++; if (obs_cycles !== 37) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 37", obs_cycles); end
    endtask

    task automatic test_shared();
        run_req(3, 0, 1'b1, 10'd55, 6'd1, 3'd1, 4'd4, 5, 50);
        n_checks++; if ({obs_done, obs_err} !== 3'b110) begin n_fail++; $display("FAIL shared_done: got %b want 110", {obs_done, obs_err}); end
        n_checks++; if (obs_cycles !== 2) begin n_fail++; $display("FAIL shared_latency: got %0d want 2", obs_cycles); end
        n_checks++; if ({div_sel, resetb} !== {7'b0000111, 3'b001}) begin n_fail++; $display("FAIL shared_outputs: got %b want 0000111001", {div_sel, resetb}); end
        n_checks++; if ({divisor[15:12], div_main[9:0]} !== {4'd0, 10'd200}) begin n_fail++; $display("FAIL shared_data: got %h want 0c8", {divisor[15:12], div_main[9:0]}); end
    endtask

    task automatic test_bad_idx();
        run_req(7, 0, 1'b0, 10'd0, 6'd0, 3'd0, 4'd2, -1, 50);
        n_checks++; if ({obs_done, obs_err, 5'(obs_cycles)} !== {3'b101, 5'd2}) begin n_fail++; $display("FAIL bad_clk_idx: done/err %b cycles %0d want 101 / 2", {obs_done, obs_err}, obs_cycles); end
        run_req(5, 3, 1'b0, 10'd0, 6'd0, 3'd0, 4'd2, -1, 50);
        n_checks++; if ({obs_done, obs_err} !== 3'b101) begin n_fail++; $display("FAIL bad_pll_idx: got %b want 101", {obs_done, obs_err}); end
        n_checks++; if ({div_sel, pll_sel} !== {7'b0000111, 7'b0000100}) begin n_fail++; $display("FAIL bad_idx_outputs: got %b want 00001110000100", {div_sel, pll_sel}); end
    endtask

    task automatic test_reset_mid();
        run_req(5, 2, 1'b1, 10'd77, 6'd2, 3'd4, 4'd8, -1, 50);
        n_checks++; if (state !== ST_PLL_LOCK) begin n_fail++; $display("FAIL mid_in_lock: got %0d want %0d", state, ST_PLL_LOCK); end
        rst_n = 1'b0;
        pll_lock = '0;
        #1;
        n_checks++; if ({req_ready, done, error} !== 4'b0000) begin n_fail++; $display("FAIL mid_ctrl_reset: got %b want 0000", {req_ready, done, error}); end
        n_checks++; if ({resetb, div_sel, pll_sel} !== '0) begin n_fail++; $display("FAIL mid_sel_reset: got %b want 0", {resetb, div_sel, pll_sel}); end
        n_checks++; if ({divisor, div_main, div_pre, div_scalar} !== '0) begin n_fail++; $display("FAIL mid_data_reset: got %h want 0", {divisor, div_main}); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL mid_state_reset: got %0d want %0d", state, ST_IDLE); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b want 1", req_ready); end
        run_req(5, 1, 1'b0, 10'd0, 6'd0, 3'd0, 4'd7, -1, 200);
        n_checks++; if ({obs_done, obs_err, 6'(obs_cycles)} !== {3'b100, 6'd37}) begin n_fail++; $display("FAIL mid_next_req: done/err %b cycles %0d want 100 / 37", {obs_done, obs_err}, obs_cycles); end
        n_checks++; if ({divisor[23:20], pll_sel[5], div_sel[5]} !== {4'd7, 2'b11}) begin n_fail++; $display("FAIL mid_next_outputs: got %b want 011111", {divisor[23:20], pll_sel[5], div_sel[5]}); end
    endtask

    initial begin
        test_reset();
        test_reprog_lock();
        test_parked_latency();
        test_park_change();
        test_lock_timeout();
        test_back_to_back();
        test_shared();
        test_bad_idx();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
